// File: rtl/axis_sync_fifo_if.sv
// -----------------------------------------------------------------------------
// axis_sync_fifo_if
//
// AXI-Stream handshake bundle used on both sides of axis_sync_fifo.
//
// Signals:
//   tvalid  producer -> consumer  word on tdata is valid
//   tready  consumer -> producer  consumer accepts the word this cycle
//   tdata   producer -> consumer  DATA_WIDTH-bit payload
//
// Modports:
//   master  drives tvalid/tdata and observes tready
//   slave   observes tvalid/tdata and drives tready
// -----------------------------------------------------------------------------
interface axis_sync_fifo_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;

  modport master (
    output tvalid,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    output tready
  );

endinterface : axis_sync_fifo_if

// File: rtl/axis_sync_fifo.sv
// -----------------------------------------------------------------------------
// axis_sync_fifo
//
// Single-clock AXI-Stream FIFO with first-word fall-through on the read side.
// Storage is a register array addressed by wrapping read/write pointers; an
// explicit occupancy counter distinguishes full from empty.
//
// Parameters:
//   DATA_WIDTH  tdata width in bits (default 8)
//   DEPTH       number of entries, power of two, at least 2 (default 16)
//
// Ports:
//   clk         single clock, rising edge
//   arstn       asynchronous active-low reset
//   s_axis      write side (slave modport): tvalid/tdata in, tready out
//   m_axis      read side (master modport): tvalid/tdata out, tready in
//   fifo_level  occupancy 0..DEPTH, registered; present only when the
//               AXIS_FIFO_LEVEL_EN macro is defined
//
// Flow-control flags (s_axis.tready, m_axis.tvalid) are registered from the
// next-cycle occupancy, so neither depends combinationally on the opposite
// side's handshake input. m_axis.tdata is a direct read of the array at the
// read pointer, which gives the one-cycle write-to-read latency.
//
// The storage array is intentionally not reset; only pointers, counter and
// flags are cleared, so reset discards contents by pointer clearing alone.
// -----------------------------------------------------------------------------
module axis_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     arstn,
  axis_sync_fifo_if.slave          s_axis,
  axis_sync_fifo_if.master         m_axis
`ifdef AXIS_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]   fifo_level
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  // Storage and state
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  s_tready_r;
  logic                  m_tvalid_r;

  // Combinational handshake decode
  logic                  wr_fire_s;
  logic                  rd_fire_s;
  logic [CNT_W-1:0]      count_nxt_s;

  // Handshake fires: qualified by the registered flags, so a full FIFO
  // ignores tvalid and an empty FIFO ignores tready.
  always_comb begin
    wr_fire_s = s_axis.tvalid & s_tready_r;
    rd_fire_s = m_tvalid_r & m_axis.tready;
  end

  // Next occupancy; a simultaneous read and write leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_fire_s, rd_fire_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage write; array has no reset so it maps onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[wr_ptr_r] <= s_axis.tdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (wr_fire_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_fire_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Occupancy counter and registered flow-control flags. s_tready_r resets
  // low and rises on the first edge after reset release because count_nxt_s
  // is then zero (not DEPTH).
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      count_r    <= CNT_ZERO;
      s_tready_r <= 1'b0;
      m_tvalid_r <= 1'b0;
    end else begin
      count_r    <= count_nxt_s;
      s_tready_r <= (count_nxt_s != CNT_DEPTH);
      m_tvalid_r <= (count_nxt_s != CNT_ZERO);
    end
  end

`ifdef AXIS_FIFO_LEVEL_EN
  logic [CNT_W-1:0] level_r;

  // Level mirror, updated on the same edge as the flags.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      level_r <= CNT_ZERO;
    end else begin
      level_r <= count_nxt_s;
    end
  end

  assign fifo_level = level_r;
`endif

  // Output drive: flags from registers, data falls through from the array.
  assign s_axis.tready = s_tready_r;
  assign m_axis.tvalid = m_tvalid_r;
  assign m_axis.tdata  = mem_r[rd_ptr_r];

endmodule : axis_sync_fifo

// File: tb/tb_axis_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_axis_sync_fifo
//
// Directed bench for axis_sync_fifo (DATA_WIDTH=8, DEPTH=16): reset, fill,
// drain, latency, steady-state wrap, randomised backpressure against a queue
// model, and reset mid-stream. fifo_level is checked only when
// AXIS_FIFO_LEVEL_EN is defined.
// -----------------------------------------------------------------------------
module tb_axis_sync_fifo;

  logic clk;
  logic arstn;

  int checks   = 0;
  int failures = 0;

  axis_sync_fifo_if #(.DATA_WIDTH(8)) s_if ();
  axis_sync_fifo_if #(.DATA_WIDTH(8)) m_if ();

`ifdef AXIS_FIFO_LEVEL_EN
  logic [4:0] fifo_level;
`endif

  axis_sync_fifo #(
    .DATA_WIDTH(8),
    .DEPTH     (16)
  ) dut (
    .clk   (clk),
    .arstn (arstn),
    .s_axis(s_if),
    .m_axis(m_if)
`ifdef AXIS_FIFO_LEVEL_EN
    ,
    .fifo_level(fifo_level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the directed sequence needs roughly 10.3k cycles.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_level(input string tag, input int exp);
`ifdef AXIS_FIFO_LEVEL_EN
    check(tag, 32'(fifo_level), 32'(exp));
`endif
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_b;
    logic [7:0] next_val;
    logic       wr_s, rd_s, hold_s;
    logic [7:0] held_data;
    int         valid_pct, ready_pct;

    // ---------------- Reset ----------------
    arstn       = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = 8'h00;
    m_if.tready = 1'b0;
    #12;
    check("reset_s_tready", 32'(s_if.tready), 32'd0);
    check("reset_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check_level("reset_level", 0);
    arstn = 1'b1;
    tick();
    check("post_reset_s_tready", 32'(s_if.tready), 32'd1);
    check("post_reset_m_tvalid", 32'(m_if.tvalid), 32'd0);

    // ---------------- Fill 0x01..0x10 ----------------
    for (int i = 1; i <= 16; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'(i);
      tick();
      check("fill_m_tvalid", 32'(m_if.tvalid), 32'd1);
      check("fill_s_tready", 32'(s_if.tready), (i == 16) ? 32'd0 : 32'd1);
    end
    check_level("full_level", 16);
    // 17th word held valid must not be accepted
    s_if.tdata = 8'h11;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_hold_s_tready", 32'(s_if.tready), 32'd0);
      check("full_hold_head", 32'(m_if.tdata), 32'h01);
      check_level("full_hold_level", 16);
    end
    s_if.tvalid = 1'b0;

    // ---------------- Drain ----------------
    m_if.tready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check("drain_m_tvalid", 32'(m_if.tvalid), 32'd1);
      check("drain_data", 32'(m_if.tdata), 32'(i));
      tick();
      check("drain_s_tready", 32'(s_if.tready), 32'd1);
    end
    check("drained_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check_level("drained_level", 0);
    m_if.tready = 1'b0;

    // ---------------- Latency ----------------
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'hA5;
    tick();
    s_if.tvalid = 1'b0;
    check("lat_m_tvalid", 32'(m_if.tvalid), 32'd1);
    check("lat_data", 32'(m_if.tdata), 32'hA5);
    m_if.tready = 1'b1;
    tick();
    check("lat_read_m_tvalid", 32'(m_if.tvalid), 32'd0);
    m_if.tready = 1'b0;

    // ---------------- Simultaneous at occupancy 8, wrap ----------------
    for (int i = 0; i < 8; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'(i);
      tick();
    end
    check_level("occ8_level", 8);
    m_if.tready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      s_if.tdata = 8'(k + 8);
      check("steady_data", 32'(m_if.tdata), 32'(k));
      tick();
      check("steady_m_tvalid", 32'(m_if.tvalid), 32'd1);
      check("steady_s_tready", 32'(s_if.tready), 32'd1);
      check_level("steady_level", 8);
    end
    s_if.tvalid = 1'b0;
    for (int k = 40; k < 48; k++) begin
      check("steady_tail_data", 32'(m_if.tdata), 32'(k));
      tick();
    end
    check("steady_empty_m_tvalid", 32'(m_if.tvalid), 32'd0);
    m_if.tready = 1'b0;

    // ---------------- Random backpressure vs queue model ----------------
    next_val    = 8'h00;
    s_if.tvalid = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      valid_pct = (c < 5000) ? 75 : 40;
      ready_pct = (c < 5000) ? 40 : 75;
      // Source holds an unaccepted word; otherwise picks a new one.
      if (!s_if.tvalid) begin
        if ($urandom_range(99, 0) < 32'(valid_pct)) begin
          s_if.tvalid = 1'b1;
          s_if.tdata  = next_val;
          next_val    = next_val + 8'd1;
        end else begin
          s_if.tvalid = 1'b0;
        end
      end
      m_if.tready = ($urandom_range(99, 0) < 32'(ready_pct));
      #1;
      wr_s      = s_if.tvalid & s_if.tready;
      rd_s      = m_if.tvalid & m_if.tready;
      hold_s    = m_if.tvalid & ~m_if.tready;
      held_data = m_if.tdata;
      if (rd_s) begin
        if (q.size() == 0) begin
          check("rnd_read_from_empty_model", 32'd1, 32'd0);
        end else begin
          exp_b = q.pop_front();
          check("rnd_data", 32'(m_if.tdata), 32'(exp_b));
        end
      end
      if (wr_s) q.push_back(s_if.tdata);
      tick();
      if (wr_s) s_if.tvalid = 1'b0;
      check("rnd_s_tready", 32'(s_if.tready), (q.size() != 16) ? 32'd1 : 32'd0);
      check("rnd_m_tvalid", 32'(m_if.tvalid), (q.size() != 0) ? 32'd1 : 32'd0);
      if (hold_s) begin
        check("rnd_stable_data", 32'(m_if.tdata), 32'(held_data));
      end
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    #1;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      exp_b = q.pop_front();
      check("rnd_final_m_tvalid", 32'(m_if.tvalid), 32'd1);
      check("rnd_final_data", 32'(m_if.tdata), 32'(exp_b));
      tick();
    end
    check("rnd_final_model_empty", 32'(q.size()), 32'd0);
    check("rnd_final_empty", 32'(m_if.tvalid), 32'd0);
    m_if.tready = 1'b0;

    // ---------------- Reset mid-stream ----------------
    for (int i = 0; i < 5; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'(8'h50 + i);
      tick();
    end
    s_if.tvalid = 1'b0;
    check_level("mid_occ5_level", 5);
    check("mid_pre_m_tvalid", 32'(m_if.tvalid), 32'd1);
    #2;
    arstn = 1'b0;
    #1;
    check("mid_rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("mid_rst_s_tready", 32'(s_if.tready), 32'd0);
    check_level("mid_rst_level", 0);
    @(negedge clk);
    arstn = 1'b1;
    tick();
    check("mid_rel_s_tready", 32'(s_if.tready), 32'd1);
    check("mid_rel_m_tvalid", 32'(m_if.tvalid), 32'd0);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'h3C;
    tick();
    s_if.tvalid = 1'b0;
    check("mid_first_m_tvalid", 32'(m_if.tvalid), 32'd1);
    check("mid_first_data", 32'(m_if.tdata), 32'h3C);
    m_if.tready = 1'b1;
    tick();
    check("mid_after_read_m_tvalid", 32'(m_if.tvalid), 32'd0);
    m_if.tready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_axis_sync_fifo

// File: doc/axis_sync_fifo.md
# axis_sync_fifo

Single-clock AXI-Stream FIFO that buffers the byte stream from the memory-driven stream source and feeds the I2C master's `s_axis` input. It sits directly upstream of the I2C master and is the in-house drop-in replacement for the vendor `axis_data_fifo`. Storage is a register array with wrap-around pointers. Both stream sides have registered flow-control outputs and fall-through data (first-word fall-through, FWFT).

## Interface
- `DATA_WIDTH`, 8: tdata width in bits; matches `AXIS_DATA_WIDTH`.
- `DEPTH`, 16: number of entries; power of two, at least 2.
- `clk`  in  1: single clock; everything is sampled on the rising edge.
- `arstn`  in  1: reset. One clock; reset is asynchronous and active-low.
- `s_axis_tvalid`  in  1: write side, data valid.
- `s_axis_tready`  out  1: write side, FIFO can accept a word.
- `s_axis_tdata`  in  DATA_WIDTH: write data.
- `m_axis_tvalid`  out  1: read side, head word valid.
- `m_axis_tready`  in  1: read side, consumer accepts the head word.
- `m_axis_tdata`  out  DATA_WIDTH: head word.
- `fifo_level`  out  $clog2(DEPTH)+1: occupancy, 0..DEPTH. Present only with `AXIS_FIFO_LEVEL_EN`.

## Operation
- Internal state:
  - `mem[DEPTH]`.
  - `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - `count`, $clog2(DEPTH)+1 bits.
- Write fire: `wr = s_axis_tvalid & s_axis_tready`. On a write, `mem[wr_ptr] <= s_axis_tdata` and `wr_ptr <= wr_ptr+1`.
- Read fire: `rd = m_axis_tvalid & m_axis_tready`. On a read, `rd_ptr <= rd_ptr+1`.
- Next count, `count_nxt`:
  - `count+1` when wr & !rd.
  - `count-1` when rd & !wr.
  - `count` otherwise, including when wr and rd fire together.
- Registered flags:
  - `s_axis_tready <= (count_nxt != DEPTH)`.
  - `m_axis_tvalid <= (count_nxt != 0)`.
- `m_axis_tdata = mem[rd_ptr]`, a combinational read of the array. It is meaningful only while `m_axis_tvalid=1`.
- Boundary conditions:
  - Full (`count=DEPTH`): `s_axis_tready=0`. No write occurs regardless of `s_axis_tvalid`. A read in that cycle raises `s_axis_tready` on the next cycle.
  - Empty (`count=0`): `m_axis_tvalid=0`. A write in that cycle raises `m_axis_tvalid` on the next cycle.
  - Wrap-around: the pointers roll from DEPTH-1 to 0 with no gap. Data order is strictly preserved across the wrap.
  - Simultaneous read and write at any occupancy: both pointers advance, count is unchanged and both flags hold.
- The FIFO never drops or duplicates a word. Without a fire, `tdata` stays stable while `tvalid` is held; this is the AXIS rule.
- Reset mid-operation: all contents are discarded, and pointers and count clear immediately (asynchronous).
- The memory array is not reset.

## Timing
- Reset values:
  - `s_axis_tready=0`, `m_axis_tvalid=0`, `count=0`, `wr_ptr=0`, `rd_ptr=0`.
  - `fifo_level=0`.
  - `m_axis_tdata` is don't-care.
- `s_axis_tready` rises on the first `clk` edge after `arstn` deasserts.
- Write-to-read latency is 1 cycle. A word accepted at edge N gives `m_axis_tvalid=1` after edge N, with that word on `m_axis_tdata`.
- Sustained throughput is one word per cycle in and out simultaneously at any occupancy between 1 and DEPTH-1.
- Flag update latency is 1 cycle from the causing fire. The flags never depend combinationally on `s_axis_tvalid` or `m_axis_tready`.

## Configuration
- `AXIS_FIFO_LEVEL_EN`
  - Defined: the port `fifo_level` is present and registered, equal to `count`. It updates on the same edge as the flags and is 0 in reset.
  - Undefined: the port and its logic are absent. FIFO behaviour is otherwise identical.

## Test plan
- Reset and fill: hold `m_axis_tready=0` and release reset.
  - `s_axis_tready` goes to 1 one cycle after release.
  - Write 0x01..0x10 back-to-back with DEPTH=16; `s_axis_tready` drops the cycle after the 16th write and `fifo_level=16`.
  - A 17th word held valid is not accepted.
- Drain: from full, assert `m_axis_tready=1`.
  - Read 0x01..0x10 in order at one word per cycle.
  - `m_axis_tvalid` drops after the 16th read; `fifo_level=0`.
- Latency: into an empty FIFO, write 0xA5 at edge N.
  - `m_axis_tvalid=1` and `m_axis_tdata=0xA5` after edge N.
  - `m_axis_tvalid=0` one cycle after it is read.
- Simultaneous and wrap: keep occupancy at 8 with both sides valid/ready for 40 cycles, writing an incrementing counter.
  - The output matches the input delayed by 8 words.
  - `fifo_level` stays at 8 while pointers wrap at least twice.
- Random backpressure: randomize `s_axis_tvalid` and `m_axis_tready` for 10000 cycles against a scoreboard.
  - No loss, duplication or reorder.
  - `tdata` is stable while valid and not ready.
- Reset mid-stream: assert `arstn=0` with occupancy 5.
  - `m_axis_tvalid` and `s_axis_tready` go to 0 immediately.
  - After release the FIFO is empty and the next word written (0x3C) is the first word read.
